// File: rtl/gcd_pkg.sv
// Shared types and limits for the GCD request scheduler and its arbiter.
package gcd_pkg;
  localparam int GCD_W        = 16;
  localparam int GCD_NREQ_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    SUB,
    RESP
  } state_t;
endpackage

// File: rtl/gcd_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr wins, one-hot grant.
module gcd_rr_arb import gcd_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  always_comb begin : arb
    int j;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any  = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/gcd_sched.sv
// Shares one subtractive GCD datapath among NREQ requesters with round-robin accept.
// Define GCD_SCHED_ZERO_CHK_EN to reject zero operands with rsp_err instead of hanging.
module gcd_sched import gcd_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W    = GCD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  output logic                     LdA,
  output logic                     LdB,
  output logic                     sel1,
  output logic                     sel2,
  output logic                     sel_in,
  output logic [W-1:0]             data_in,
  input  logic                     LT,
  input  logic                     GT,
  input  logic                     EQ,
  input  logic [W-1:0]             Aout
);
  localparam int IDW = $clog2(NREQ);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [W-1:0]    sel_a, sel_b;
  logic [W-1:0]    a_q, b_q;
  logic            gt_q, lt_q;
  logic            zero_q;

  gcd_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && gnt_any;
  assign sel_a     = req_a[gnt_idx*W +: W];
  assign sel_b     = req_b[gnt_idx*W +: W];

`ifdef GCD_SCHED_ZERO_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      zero_q <= 1'b0;
    else if (accept)
      zero_q <= (sel_a == '0) || (sel_b == '0);
  end
  assign rsp_err = zero_q;
`else
  assign zero_q  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          state  <= LOAD_A;
          rsp_id <= gnt_idx;
          ptr    <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        LOAD_A: if (zero_q) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
        end else begin
          state <= LOAD_B;
        end
        LOAD_B: state <= CMP;
        CMP: if (EQ) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= Aout;
        end else begin
          state <= SUB;
        end
        SUB:  state <= CMP;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Job operands and comparator flags are pure data: no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= sel_a;
      b_q <= sel_b;
    end
    if (state == CMP) begin
      gt_q <= GT;
      lt_q <= LT;
    end
  end

  always_comb begin
    LdA     = 1'b0;
    LdB     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel_in  = 1'b0;
    data_in = '0;
    case (state)
      LOAD_A: if (!zero_q) begin
        sel_in  = 1'b1;
        data_in = a_q;
        LdA     = 1'b1;
      end
      LOAD_B: begin
        sel_in  = 1'b1;
        data_in = b_q;
        LdB     = 1'b1;
      end
      SUB: if (gt_q) begin
        sel2 = 1'b1;
        LdA  = 1'b1;
      end else if (lt_q) begin
        sel1 = 1'b1;
        LdB  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gcd_sched.sv
// Bench for gcd_sched with a behavioural subtractive datapath and a result scoreboard.
module tb_gcd_sched;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              LdA, LdB, sel1, sel2, sel_in;
  logic [W-1:0]      data_in;
  logic              LT, GT, EQ;
  logic [W-1:0]      Aout;

  always #5 clk = ~clk;

  gcd_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .LdA(LdA), .LdB(LdB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .data_in(data_in), .LT(LT), .GT(GT), .EQ(EQ), .Aout(Aout)
  );

  // Datapath model: A/B registers, operand muxes, subtractor, comparator
  logic [W-1:0] ra = '0, rb = '0;
  logic [W-1:0] op1, op2, mux;
  assign op1  = sel1 ? rb : ra;
  assign op2  = sel2 ? rb : ra;
  assign mux  = sel_in ? data_in : (op1 - op2);
  assign LT   = ra < rb;
  assign GT   = ra > rb;
  assign EQ   = ra == rb;
  assign Aout = ra;
  always @(posedge clk) begin
    if (LdA) ra <= mux;
    if (LdB) rb <= mux;
  end

  int cyc = 0;
  int sub_seen = 0;
  int ld_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sel1 | sel2) sub_seen <= sub_seen + 1;
    if (LdA | LdB)   ld_seen  <= ld_seen + 1;
  end

  typedef struct {
    logic [W-1:0] data;
    int           id;
    int           lat;
    int           t0;
    logic         err;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad = 0;

  int bA[5]  = '{143, 1000, 17, 65535, 360};
  int bB[5]  = '{78,  1,    5,  65535, 84};
  int bId[5] = '{0,   1,    2,  3,     1};

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b,
                                           output int s);
    s = 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      s++;
    end
    return a;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_accept(input int maxc, output int idx, output int t0, output bit ok);
    ok = 1'b0; idx = -1; t0 = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        t0 = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int maxc, output int t1, output bit ok);
    ok = 1'b0; t1 = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        t1 = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp: got v=%0b d=%0d id=%0d e=%0b, want all 0",
               rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    total++;
    if ({LdA, LdB, sel1, sel2, sel_in} !== 5'b0 || data_in !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got ctl=%b din=%0d, want 0", {LdA, LdB, sel1, sel2, sel_in}, data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got req_ready=%b rsp_valid=%0b, want 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_basic();
    int idx, t0, t1, s;
    bit ok;
    exp_t e;
    sbq.delete();
    for (int k = 0; k < 5; k++) begin
      set_req(bId[k], W'(bA[k]), W'(bB[k]));
      wait_accept(20, idx, t0, ok);
      total++;
      if (!ok || idx != bId[k]) begin
        bad++;
        $display("FAIL basic_accept[%0d]: got idx=%0d ok=%0b, want idx=%0d", k, idx, ok, bId[k]);
      end
      e.data = ref_gcd(W'(bA[k]), W'(bB[k]), s);
      e.id = bId[k]; e.lat = 4 + 2*s; e.t0 = t0; e.err = 1'b0;
      sbq.push_back(e);
      @(posedge clk); #1;
      req_valid[bId[k]] = 1'b0;
      wait_rsp(e.lat + 8, t1, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL basic_timeout[%0d]: no rsp_valid, want one after %0d cycles", k, e.lat);
      end else begin
        e = sbq.pop_front();
        total++;
        if (rsp_data !== e.data) begin
          bad++;
          $display("FAIL basic_data[%0d]: got %0d want %0d", k, rsp_data, e.data);
        end
        total++;
        if (rsp_id !== IDW'(e.id)) begin
          bad++;
          $display("FAIL basic_id[%0d]: got %0d want %0d", k, rsp_id, e.id);
        end
        total++;
        if (t1 - e.t0 != e.lat) begin
          bad++;
          $display("FAIL basic_latency[%0d]: got %0d want %0d", k, t1 - e.t0, e.lat);
        end
        total++;
        if (rsp_err !== e.err) begin
          bad++;
          $display("FAIL basic_err[%0d]: got %0b want %0b", k, rsp_err, e.err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_equal();
    int idx, t0, t1, s0, s;
    bit ok;
    exp_t e;
    sbq.delete();
    s0 = sub_seen;
    set_req(0, 16'd21, 16'd21);
    wait_accept(20, idx, t0, ok);
    e.data = ref_gcd(16'd21, 16'd21, s);
    e.id = 0; e.lat = 4 + 2*s; e.t0 = t0; e.err = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(20, t1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL equal_timeout: no rsp_valid, want one after 4 cycles");
    end else begin
      e = sbq.pop_front();
      total++;
      if (rsp_data !== e.data || t1 - e.t0 != e.lat) begin
        bad++;
        $display("FAIL equal_result: got d=%0d lat=%0d want d=%0d lat=%0d",
                 rsp_data, t1 - e.t0, e.data, e.lat);
      end
    end
    @(posedge clk); #1;
    total++;
    if (sub_seen != s0) begin
      bad++;
      $display("FAIL equal_no_sub: got %0d SUB cycles want 0", sub_seen - s0);
    end
  endtask

  task automatic test_rr();
    int idx, t0, t1, s, want;
    bit ok;
    exp_t e;
    do_reset();
    sbq.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, W'(30*(i+1)), 16'd12);
    for (int n = 0; n < 5; n++) begin
      want = n % NREQ;
      wait_accept(20, idx, t0, ok);
      total++;
      if (!ok || idx != want) begin
        bad++;
        $display("FAIL rr_order[%0d]: got idx=%0d ok=%0b, want idx=%0d", n, idx, ok, want);
      end
      e.data = ref_gcd(W'(30*(want+1)), 16'd12, s);
      e.id = want; e.lat = 4 + 2*s; e.t0 = t0; e.err = 1'b0;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (n == 4) req_valid = '0;
      wait_rsp(e.lat + 8, t1, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rr_timeout[%0d]: no rsp_valid", n);
      end else begin
        e = sbq.pop_front();
        total++;
        if (rsp_data !== e.data || rsp_id !== IDW'(e.id) || t1 - e.t0 != e.lat) begin
          bad++;
          $display("FAIL rr_rsp[%0d]: got d=%0d id=%0d lat=%0d want d=%0d id=%0d lat=%0d",
                   n, rsp_data, rsp_id, t1 - e.t0, e.data, e.id, e.lat);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure();
    int idx, t0, t1, s;
    bit ok;
    exp_t e;
    sbq.delete();
    rsp_ready = 1'b0;
    set_req(0, 16'd48, 16'd18);
    wait_accept(20, idx, t0, ok);
    e.data = ref_gcd(16'd48, 16'd18, s);
    e.id = 0; e.lat = 4 + 2*s; e.t0 = t0; e.err = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 16'd21, 16'd21);
    wait_rsp(e.lat + 8, t1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL hold_timeout: no rsp_valid");
    end
    e = sbq.pop_front();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== IDW'(e.id) || req_ready !== '0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got v=%0b d=%0d id=%0d rdy=%b want v=1 d=%0d id=%0d rdy=0",
                 c, rsp_valid, rsp_data, rsp_id, req_ready, e.data, e.id);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    wait_accept(20, idx, t0, ok);
    total++;
    if (!ok || idx != 1) begin
      bad++;
      $display("FAIL hold_pending: got idx=%0d ok=%0b, want idx=1", idx, ok);
    end
    e.data = ref_gcd(16'd21, 16'd21, s);
    e.id = 1; e.lat = 4 + 2*s; e.t0 = t0; e.err = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(e.lat + 8, t1, ok);
    e = sbq.pop_front();
    total++;
    if (!ok || rsp_data !== e.data || rsp_id !== IDW'(e.id)) begin
      bad++;
      $display("FAIL hold_second: got ok=%0b d=%0d id=%0d want d=%0d id=%0d",
               ok, rsp_data, rsp_id, e.data, e.id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    int idx, t0, t1, s;
    bit ok, in_sub;
    exp_t e;
    sbq.delete();
    set_req(3, 16'd143, 16'd78);
    wait_accept(20, idx, t0, ok);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    in_sub = 1'b0;
    for (int c = 0; c < 30 && !in_sub; c++) begin
      @(negedge clk);
      in_sub = sel1 | sel2;
    end
    total++;
    if (!in_sub) begin
      bad++;
      $display("FAIL abort_reach_sub: got no SUB cycle, want one");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || req_ready !== '0 ||
        {LdA, LdB, sel1, sel2, sel_in} !== 5'b0) begin
      bad++;
      $display("FAIL abort_async: got v=%0b d=%0d id=%0d rdy=%b ctl=%b want all 0",
               rsp_valid, rsp_data, rsp_id, req_ready, {LdA, LdB, sel1, sel2, sel_in});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_rsp[%0d]: got rsp_valid=%0b want 0", c, rsp_valid);
      end
    end
    rst_n = 1'b1;
    set_req(2, 16'd48, 16'd18);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL abort_first_idle: got req_ready=%b want 0100", req_ready);
    end
    e.data = ref_gcd(16'd48, 16'd18, s);
    e.id = 2; e.lat = 4 + 2*s; e.t0 = cyc; e.err = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp(e.lat + 8, t1, ok);
    e = sbq.pop_front();
    total++;
    if (!ok || rsp_data !== e.data || rsp_id !== IDW'(e.id) || t1 - e.t0 != e.lat) begin
      bad++;
      $display("FAIL abort_next_job: got ok=%0b d=%0d id=%0d lat=%0d want d=%0d id=%0d lat=%0d",
               ok, rsp_data, rsp_id, t1 - e.t0, e.data, e.id, e.lat);
    end
    @(posedge clk); #1;
  endtask

`ifdef GCD_SCHED_ZERO_CHK_EN
  task automatic test_zero_chk();
    int idx, t0, t1, l0;
    bit ok;
    exp_t e;
    sbq.delete();
    l0 = ld_seen;
    set_req(1, 16'd0, 16'd5);
    wait_accept(20, idx, t0, ok);
    e.data = '0; e.id = 1; e.lat = 2; e.t0 = t0; e.err = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(10, t1, ok);
    e = sbq.pop_front();
    total++;
    if (!ok || rsp_err !== e.err || rsp_data !== e.data || t1 - e.t0 != e.lat) begin
      bad++;
      $display("FAIL zero_rsp: got ok=%0b e=%0b d=%0d lat=%0d want e=1 d=0 lat=2",
               ok, rsp_err, rsp_data, t1 - e.t0);
    end
    @(posedge clk); #1;
    total++;
    if (ld_seen != l0) begin
      bad++;
      $display("FAIL zero_no_load: got %0d load cycles want 0", ld_seen - l0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_rr();
    test_back_pressure();
    test_reset_mid_job();
`ifdef GCD_SCHED_ZERO_CHK_EN
    test_zero_chk();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule

// File: doc/gcd_sched.md
GCD_SCHED -- requirements
Module: gcd_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one gcd_datapath, range 2..8.
REQ-002 SHALL have parameter W, default 16: operand/result width, matching the datapath bus.
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester job valid.
REQ-006 SHALL have port req_a, input, NREQ*W: per-requester operand A, packed, requester i at [i*W +: W].
REQ-007 SHALL have port req_b, input, NREQ*W: per-requester operand B, packed as req_a.
REQ-008 SHALL have port req_ready, output, NREQ: one-hot job-accept strobe.
REQ-009 SHALL have port rsp_valid, output, 1: result valid.
REQ-010 SHALL have port rsp_ready, input, 1: result consumer ready.
REQ-011 SHALL have port rsp_data, output, W: GCD result.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ): index of the requester owning rsp_data.
REQ-013 SHALL have port rsp_err, output, 1: zero-operand error flag; tied 0 without the REQ-031 macro.
REQ-014 SHALL have ports LdA, LdB, sel1, sel2, sel_in, output, 1 each: datapath controls.
REQ-015 SHALL have port data_in, output, W: datapath load value.
REQ-016 SHALL have ports LT, GT, EQ, input, 1 each: datapath comparator flags.
REQ-017 SHALL have port Aout, input, W: datapath register A readback.

Function
REQ-018 SHALL implement states IDLE, LOAD_A, LOAD_B, CMP, SUB, RESP with registered state and combinational (Moore) datapath controls; no # delays.
REQ-019 IDLE: SHALL raise req_ready[g] for one cycle, where g is the round-robin winner among req_valid, starting search at ptr; the handshake moves the state to LOAD_A and latches g, a, b.
REQ-020 Round-robin pointer SHALL become g+1 mod NREQ on each accept; with no req_valid set, the block stays in IDLE and ptr is held.
REQ-021 LOAD_A SHALL drive sel_in=1, data_in=a, LdA=1; LOAD_B SHALL drive sel_in=1, data_in=b, LdB=1; all other controls SHALL be 0.
REQ-022 CMP SHALL drive all loads to 0; on EQ it SHALL go to RESP capturing Aout into rsp_data; otherwise it SHALL go to SUB.
REQ-023 SUB SHALL be entered with the flags sampled in CMP held in a register; GT SHALL drive sel1=0, sel2=1, sel_in=0, LdA=1 (A<=A-B); LT SHALL drive sel1=1, sel2=0, sel_in=0, LdB=1 (B<=B-A); next state SHALL be CMP.
REQ-024 Latency SHALL be exactly 4+2*S cycles from the accept edge to rsp_valid, where S is the number of subtractions.
REQ-025 RESP SHALL hold rsp_valid, rsp_data and rsp_id stable until rsp_valid&&rsp_ready, then return to IDLE; no new job SHALL be accepted while in RESP.
REQ-026 req_ready SHALL be 0 outside IDLE; requesters not granted SHALL remain pending with no loss.
REQ-027 All arithmetic SHALL be unsigned, W bits.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, and all datapath controls to 0, including mid-job.
REQ-029 An aborted job SHALL produce no response; the first cycle after release SHALL be IDLE arbitration.

Configuration
REQ-030 Macro GCD_SCHED_ZERO_CHK_EN SHALL select zero-operand checking.
REQ-031 With GCD_SCHED_ZERO_CHK_EN defined: if a==0 or b==0 at accept, the block SHALL go directly to RESP the next cycle with rsp_err=1 and rsp_data=0, without loading the datapath. Without the macro, no check SHALL be made and rsp_err SHALL be tied to 0; a zero operand SHALL hang in CMP/SUB until reset, which is documented behaviour.

Structure
REQ-032 Package gcd_pkg SHALL hold the state enum, default W, and the NREQ upper bound.
REQ-033 Round-robin arbitration SHALL be a sub-module gcd_rr_arb (request vector, pointer, one-hot grant).

Verification
REQ-034 Requester 0, a=143, b=78 -> rsp_data=13, rsp_id=0, rsp_valid asserted 16 cycles after accept (S=6).
REQ-035 a=b=21 -> rsp_data=21 at 4 cycles after accept, with no SUB state entered.
REQ-036 All four req_valid held with ptr=0 -> accepts occur in order 0,1,2,3,0, with rsp_id matching each accept.
REQ-037 rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data and rsp_id stable, and all req_ready=0 throughout.
REQ-038 rst_n pulsed low during SUB -> outputs reach reset values immediately, no response is issued, and the next job (48,18) returns 6.
REQ-039 With GCD_SCHED_ZERO_CHK_EN, a=0, b=5 -> rsp_err=1, rsp_data=0, 2 cycles after accept, and LdA/LdB are never asserted.
